fifo_frame_packer: RTL

Read-side consumer of the asynchronous FIFO, clocked in the read domain.
- Pops 8-bit words from the FIFO's show-ahead output and groups them into fixed-length frames.
- Each frame is a header byte, frame_len payload bytes and a two's-complement checksum byte.
- Frames are presented on a valid/ready byte stream to the downstream transmitter, with start/end-of-frame markers and a running frame counter.

---
 rtl/fifo_frame_packer_if.sv | 25 ++
 rtl/fifo_frame_packer.sv | 109 ++++++++++
 2 files changed

// File: rtl/fifo_frame_packer_if.sv
// Bundle between the read-side FIFO, the frame packer and the downstream byte stream.
// Stream handshake: a byte moves on a rising edge where out_valid and out_ready are both high.
interface fifo_frame_packer_if #(
  parameter int data_size = 8
);
  logic                 r_empty;
  logic [data_size-1:0] din;
  logic                 rd_en;
  logic [data_size-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sof;
  logic                 out_eof;
  logic [7:0]           frame_cnt;

  modport master (
    input  r_empty, din, out_ready,
    output rd_en, out_data, out_valid, out_sof, out_eof, frame_cnt
  );

  modport slave (
    output r_empty, din, out_ready,
    input  rd_en, out_data, out_valid, out_sof, out_eof, frame_cnt
  );
endinterface

// File: rtl/fifo_frame_packer.sv
// Pops show-ahead FIFO words and emits header / frame_len payload bytes / checksum frames.
// The checksum is the two's complement of the payload sum, so payload plus checksum is 0.
module fifo_frame_packer #(
  parameter int                   data_size = 8,
  parameter int                   frame_len = 4,
  parameter logic [data_size-1:0] hdr_byte  = 8'hA5
) (
  input  logic                 clk_read,
  input  logic                 reset,
  fifo_frame_packer_if.master  bus,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HEADER   = 2'd1,
    S_PAYLOAD  = 2'd2,
    S_CHECKSUM = 2'd3
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(frame_len - 1);

  state_t               r_state;
  state_t               w_next;
  logic [7:0]           r_idx;
  logic [data_size-1:0] r_sum;
  logic [7:0]           r_frame_cnt;

  logic                 w_valid;
  logic                 w_sof;
  logic                 w_eof;
  logic                 w_rd_en;
  logic                 w_xfer;
  logic [data_size-1:0] w_data;

  always_comb begin
    w_next  = r_state;
    w_valid = 1'b0;
    w_sof   = 1'b0;
    w_eof   = 1'b0;
    w_rd_en = 1'b0;
    w_data  = '0;
    case (r_state)
      S_IDLE: begin
        if (!bus.r_empty) w_next = S_HEADER;
      end
      S_HEADER: begin
        w_valid = 1'b1;
        w_sof   = 1'b1;
        w_data  = hdr_byte;
        if (bus.out_ready) w_next = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        // Payload bytes stream straight from the show-ahead port; a pop is a transfer.
        w_valid = ~bus.r_empty;
        if (w_valid) w_data = bus.din;
        w_rd_en = w_valid & bus.out_ready;
        if (w_rd_en && (r_idx == LAST_IDX)) w_next = S_CHECKSUM;
      end
      S_CHECKSUM: begin
        w_valid = 1'b1;
        w_eof   = 1'b1;
        w_data  = (~r_sum) + data_size'(1);
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_xfer = w_valid & bus.out_ready;

  always_ff @(posedge clk_read) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= 8'd0;
      r_sum       <= '0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_HEADER: begin
          if (w_xfer) begin
            r_idx <= 8'd0;
            r_sum <= '0;
          end
        end
        S_PAYLOAD: begin
          if (w_xfer) begin
            r_sum <= r_sum + bus.din;
            r_idx <= r_idx + 8'd1;
          end
        end
        S_CHECKSUM: begin
          if (w_xfer) r_frame_cnt <= r_frame_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_en     = w_rd_en;
  assign bus.out_data  = w_data;
  assign bus.out_valid = w_valid;
  assign bus.out_sof   = w_sof;
  assign bus.out_eof   = w_eof;
  assign bus.frame_cnt = r_frame_cnt;
  assign o_dbg_state   = r_state;

endmodule
